multi_tap_delay_line: RTL and testbench
=======================================

Name: multi_tap_delay_line

Overview:
- Parametrised successor to the two-tap single-bit shifter: a WIDTH-bit-wide, DEPTH-deep shift line with NTAPS independent output taps.
- Each tap's delay is runtime-programmable.
- Shifting is gated by a valid strobe.
- A fill counter reports per tap whether the selected stage holds a real sample since the last reset or flush.
- Used in etchnet datapaths wherever aligned, delayed copies of a stream feed several consumers.

Parameters:
- WIDTH, 8, bits per sample.
- DEPTH, 16, number of shift stages (must be >= 2).
- NTAPS, 2, number of output taps (must be >= 1).
- SELW, $clog2(DEPTH+1), width of one tap delay field (derived localparam; not overridable).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of line contents and fill count.
- in_valid  input  1  shift enable; a sample is accepted when high.
- data  input  WIDTH  input sample.
- tap_delay  input  NTAPS*SELW  packed per-tap delay; tap k uses bits [k*SELW +: SELW].
- out_data  output  NTAPS*WIDTH  packed tap outputs; tap k on [k*WIDTH +: WIDTH].
- out_valid  output  NTAPS  per-tap "sample is real" flag.
- fill  output  SELW  number of accepted samples since reset/flush, saturating at DEPTH.

Behaviour:
- Storage: stage[0..DEPTH-1], each WIDTH bits; stage[0] holds the newest sample.
- Shift: on a clk edge with in_valid=1 (and no rst/flush), stage[0] <= data and stage[i] <= stage[i-1] for i = 1..DEPTH-1. The oldest sample is discarded.
- Hold: with in_valid=0, all stages and fill hold their values.
- Tap mapping: effective delay d_k = clamp(tap_delay field, 1, DEPTH).
  - A field value of 0 is treated as 1; values > DEPTH are treated as DEPTH.
  - out_data tap k = stage[d_k-1]. A sample accepted at edge n appears on a tap with d=1 right after edge n, and on a tap with d=D after D accepted shifts.
- Combinational outputs: tap selection and out_valid are combinational from the registers and tap_delay. Changing tap_delay takes effect in the same cycle, with no pipeline flush.
- fill:
  - Increments by 1 on each accepted shift while fill < DEPTH; saturates at DEPTH.
  - Never wraps.
- out_valid[k] = (fill >= d_k).
- Reset (rst=1): all stages <= 0, fill <= 0. Hence out_data = 0 and out_valid = 0 on all taps from the next cycle.
- Flush (flush=1, rst=0): same effect as reset. rst has priority over flush.
- Simultaneous flush and in_valid: flush wins; the input sample is dropped and fill becomes 0, not 1.
- Reset or flush mid-stream discards all in-flight samples; there is no partial retention.
- Nonblocking assignments only; no combinational loops; no latches.

Optional Feature:
- Macro TAP_OUTPUT_REG_EN.
- When defined:
  - out_data and out_valid are registered through one extra flop stage, adding 1 cycle of latency to both, including the effect of a tap_delay change.
  - The output registers clear on rst or flush in the same edge as the line.
  - fill stays unregistered.
- When undefined: outputs are combinational as described under Behaviour.

Test Plan:
- Reset then fill: WIDTH=8, DEPTH=16, tap0 delay=1, tap1 delay=8. Drive in_valid=1 with data 0x01,0x02,... on consecutive cycles.
  - Tap0 shows 0x01 after the first edge with out_valid[0]=1.
  - Tap1 out_valid goes 1 after the 8th edge, showing 0x01.
  - fill saturates at 16 after 16 edges.
- Gated shifting: alternate in_valid 1/0 while streaming 0xA0.. -> stages advance only on valid edges. Tap1 (d=8) shows 0xA0 only after the 8th accepted sample, and fill counts only accepted samples.
- Clamping: tap_delay field 0 behaves exactly as 1; field 17 (DEPTH=16) behaves exactly as 16. With a full line of 0x01..0x10, a tap set to 17 shows 0x01.
- Runtime retap: with a full line of 0x01..0x10, change tap0 from 1 to 4 -> out_data tap0 switches from 0x10 to 0x0D in the same cycle (one cycle later with TAP_OUTPUT_REG_EN).
- Flush collision: with a full line, assert flush and in_valid together with data 0xFF -> next cycle fill=0, all out_valid=0, all out_data=0. The following accepted sample 0x55 appears on a d=1 tap with fill=1.
- Reset mid-stream: assert rst for 1 cycle after 5 accepted samples -> all outputs 0 and fill=0. Priority check: with rst=1 and flush=0, in_valid=1 accepts nothing.

Source files
------------

// File: rtl/multi_tap_delay_line.sv
// multi_tap_delay_line: gated WIDTH x DEPTH shift line with NTAPS runtime-programmable taps and fill tracking; define TAP_OUTPUT_REG_EN to register tap outputs
module multi_tap_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int NTAPS = 2,
    localparam int SELW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       data,
    input  logic [NTAPS*SELW-1:0]  tap_delay,
    output logic [NTAPS*WIDTH-1:0] out_data,
    output logic [NTAPS-1:0]       out_valid,
    output logic [SELW-1:0]        fill
);
    logic [WIDTH-1:0]       stage [DEPTH];
    logic [SELW-1:0]        fill_q;
    logic [NTAPS*WIDTH-1:0] tap_data;
    logic [NTAPS-1:0]       tap_valid;

    // shift line and saturating fill count; rst/flush drop everything including a colliding sample
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            fill_q <= '0;
        end else if (in_valid) begin
            stage[0] <= data;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            if (fill_q < SELW'(DEPTH)) fill_q <= fill_q + 1'b1;
        end
    end

    // clamp each tap delay into 1..DEPTH, pick that stage and flag it real once fill reaches it
    always_comb begin
        logic [SELW-1:0] f;
        logic [SELW-1:0] d;
        tap_data  = '0;
        tap_valid = '0;
        f = '0;
        d = '0;
        for (int k = 0; k < NTAPS; k++) begin
            f = tap_delay[k*SELW +: SELW];
            d = (f == '0) ? SELW'(1) : (f > SELW'(DEPTH) ? SELW'(DEPTH) : f);
            for (int j = 0; j < DEPTH; j++)
                if (d == SELW'(j + 1)) tap_data[k*WIDTH +: WIDTH] = stage[j];
            tap_valid[k] = fill_q >= d;
        end
    end

    assign fill = fill_q;

`ifdef TAP_OUTPUT_REG_EN
    // one-cycle output register, cleared together with the line
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_data  <= '0;
            out_valid <= '0;
        end else begin
            out_data  <= tap_data;
            out_valid <= tap_valid;
        end
    end
`else
    assign out_data  = tap_data;
    assign out_valid = tap_valid;
`endif
endmodule

// File: tb/tb_multi_tap_delay_line.sv
// tb_multi_tap_delay_line: scoreboard bench with a reference line model for multi_tap_delay_line
module tb_multi_tap_delay_line;
    localparam int W = 8;
    localparam int D = 16;
    localparam int N = 2;
    localparam int S = 5;

    logic clk = 1'b0;
    logic rst, flush, in_valid;
    logic [W-1:0] data;
    logic [N*S-1:0] tap_delay;
    logic [N*W-1:0] out_data;
    logic [N-1:0] out_valid;
    logic [S-1:0] fill;

    multi_tap_delay_line #(.WIDTH(W), .DEPTH(D), .NTAPS(N)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .data(data),
        .tap_delay(tap_delay), .out_data(out_data), .out_valid(out_valid), .fill(fill)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        logic [N*W-1:0] od;
        logic [N-1:0] ov;
        logic [S-1:0] fl;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    logic [W-1:0] ms [D];
    int mfill = 0;
    logic [N*W-1:0] rd = '0;
    logic [N-1:0] rv = '0;

    function automatic void model_out(output logic [N*W-1:0] od, output logic [N-1:0] ov);
        od = '0;
        ov = '0;
        for (int k = 0; k < N; k++) begin
            int f = int'(tap_delay[k*S +: S]);
            int dd = f < 1 ? 1 : (f > D ? D : f);
            od[k*W +: W] = ms[dd-1];
            ov[k] = mfill >= dd;
        end
    endfunction

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard empty");
            return;
        end
        e = sb.pop_front();
        tests++;
        assert (out_data === e.od) else begin
            fails++;
            $error("FAIL %s out_data got %h exp %h", e.tag, out_data, e.od);
        end
        tests++;
        assert (out_valid === e.ov) else begin
            fails++;
            $error("FAIL %s out_valid got %b exp %b", e.tag, out_valid, e.ov);
        end
        tests++;
        assert (fill === e.fl) else begin
            fails++;
            $error("FAIL %s fill got %0d exp %0d", e.tag, fill, e.fl);
        end
    endtask

    task automatic cyc(input logic r, input logic f, input logic v, input logic [W-1:0] dt, input string tag);
        logic [N*W-1:0] pd;
        logic [N-1:0] pv;
        exp_t e;
        rst = r;
        flush = f;
        in_valid = v;
        data = dt;
        model_out(pd, pv);
        if (r || f) begin
            for (int i = 0; i < D; i++) ms[i] = '0;
            mfill = 0;
        end else if (v) begin
            for (int i = D - 1; i > 0; i--) ms[i] = ms[i-1];
            ms[0] = dt;
            if (mfill < D) mfill++;
        end
`ifdef TAP_OUTPUT_REG_EN
        rd = (r || f) ? '0 : pd;
        rv = (r || f) ? '0 : pv;
        e.od = rd;
        e.ov = rv;
`else
        model_out(e.od, e.ov);
`endif
        e.fl = S'(mfill);
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check();
    endtask

    task automatic retap(input logic [N*S-1:0] td, input string tag);
        exp_t e;
        tap_delay = td;
`ifdef TAP_OUTPUT_REG_EN
        e.od = rd;
        e.ov = rv;
`else
        model_out(e.od, e.ov);
`endif
        e.fl = S'(mfill);
        e.tag = tag;
        sb.push_back(e);
        #1;
        check();
    endtask

    task automatic expect_fill(input int v, input string tag);
        tests++;
        assert (fill === S'(v)) else begin
            fails++;
            $error("FAIL %s fill got %0d exp %0d", tag, fill, v);
        end
    endtask

    initial begin
        for (int i = 0; i < D; i++) ms[i] = '0;
        tap_delay = {5'd8, 5'd1};
        cyc(1, 0, 0, 8'h00, "reset0");
        cyc(1, 0, 1, 8'h3C, "reset1");
        expect_fill(0, "reset_fill");

        for (int i = 1; i <= 16; i++) cyc(0, 0, 1, W'(i), "fill");
        expect_fill(16, "fill_sat");
        cyc(0, 0, 0, 8'h77, "hold");
        expect_fill(16, "hold_fill");

        retap({5'd17, 5'd0}, "clamp_17_0");
        retap({5'd16, 5'd1}, "clamp_16_1");
        retap({5'd31, 5'd4}, "retap_4");
        retap({5'd8, 5'd1}, "retap_back");

        cyc(0, 1, 1, 8'hFF, "flush_collide");
        expect_fill(0, "flush_fill");
        cyc(0, 0, 1, 8'h55, "post_flush");
        expect_fill(1, "post_flush_fill");

        cyc(0, 1, 0, 8'h00, "flush2");
        for (int i = 0; i < 16; i++) cyc(0, 0, (i % 2) == 0, 8'hA0 + W'(i / 2), "gated");
        expect_fill(8, "gated_fill");
        cyc(0, 0, 0, 8'h00, "gated_tail");

        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'h30 + W'(i), "pre_rst");
        cyc(1, 0, 1, 8'h99, "rst_mid");
        expect_fill(0, "rst_mid_fill");
        cyc(1, 0, 1, 8'h9A, "rst_priority");
        cyc(0, 0, 0, 8'h00, "after_rst");

        for (int i = 0; i < 60; i++) begin
            if (i % 3 == 0) retap(N*S'($urandom), "rand_retap");
            cyc(0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, W'($urandom), "rand");
        end

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard leftover got %0d exp 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
